// File: rtl/rf_writeback_buffer_pkg.sv
// Shared constants for the register-file writeback buffer.
//   DEF_DEPTH / DEF_ADDR_W / DEF_DATA_W : default queue depth and RV32I widths
//   REG_ZERO_IDX                        : index of the hard-wired zero register
package rf_writeback_buffer_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int REG_ZERO_IDX = 0;

endpackage

// File: rtl/rf_writeback_buffer_fifo.sv
// Circular in-order storage for pending register writes.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   push, push_rd/data    enqueue one entry at the tail (caller guarantees !full)
//   pop                   retire the head entry (caller guarantees !empty)
//   head_rd, head_data    oldest pending entry
//   head_ptr              index of the oldest entry, used to walk entries by age
//   entry_vld/rd/data     flattened view of every slot for forwarding compares
//   count, full, empty    occupancy
module rf_writeback_buffer_fifo
    import rf_writeback_buffer_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_rd,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_rd,
    output logic [DATA_W-1:0]          head_data,
    output logic [PTR_W-1:0]           head_ptr,
    output logic [DEPTH-1:0]           entry_vld,
    output logic [DEPTH*ADDR_W-1:0]    entry_rd,
    output logic [DEPTH*DATA_W-1:0]    entry_data,
    output logic [CNT_W-1:0]           count,
    output logic                       full,
    output logic                       empty
);

    logic [ADDR_W-1:0] mem_rd_q   [DEPTH];
    logic [ADDR_W-1:0] mem_rd_d   [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [DATA_W-1:0] mem_data_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        vld_d      = vld_q;
        head_d     = head_q;
        tail_d     = tail_q;
        // Power-of-two depth: pointer overflow is the wrap to slot 0.
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end
        if (push) begin
            mem_rd_d[tail_q]   = push_rd;
            mem_data_d[tail_q] = push_data;
            vld_d[tail_q]      = 1'b1;
            tail_d             = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            vld_q      <= vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i*ADDR_W +: ADDR_W]   = mem_rd_q[i];
            entry_data[i*DATA_W +: DATA_W] = mem_data_q[i];
        end
    end

    assign entry_vld = vld_q;
    assign head_rd   = mem_rd_q[head_q];
    assign head_data = mem_data_q[head_q];
    assign head_ptr  = head_q;
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/rf_writeback_buffer.sv
// Writeback buffer in front of the single register-file write port.
// Ports:
//   alu_valid/rd/data, alu_ready   ALU result stream (fixed priority)
//   ld_valid/rd/data,  ld_ready    load-unit result stream
//   RegWrite, rd, rd_write_data    register-file write port, one drain per cycle
//   rs1/rs2, rsX_fwd_hit/data      forwarding of pending values to decode
//   empty                          no pending entries
// Handshake: a producer's result transfers on a rising edge where its valid and
// ready are both high; ready never depends on the producer's own valid, and a
// producer holds valid/rd/data stable until it sees ready.
module rf_writeback_buffer
    import rf_writeback_buffer_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] rd_write_data,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_fwd_hit,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic              rs2_fwd_hit,
    output logic [DATA_W-1:0] rs2_fwd_data,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(REG_ZERO_IDX);

    logic                    full, fifo_empty, push, pop;
    logic                    alu_acc, ld_acc;
    logic [ADDR_W-1:0]       push_rd, head_rd;
    logic [DATA_W-1:0]       push_data, head_data;
    logic [PTR_W-1:0]        head_ptr, idx;
    logic [DEPTH-1:0]        entry_vld;
    logic [DEPTH*ADDR_W-1:0] entry_rd;
    logic [DEPTH*DATA_W-1:0] entry_data;
    logic [CNT_W-1:0]        count;

    assign alu_ready = !full;
    assign ld_ready  = !full && !alu_valid;
    assign alu_acc   = alu_valid && alu_ready;
    assign ld_acc    = ld_valid && ld_ready;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign push_rd   = alu_acc ? alu_rd : ld_rd;
    assign push_data = alu_acc ? alu_data : ld_data;
    assign push      = (alu_acc || ld_acc) && (push_rd != REG_ZERO);
    assign pop       = !fifo_empty;

    rf_writeback_buffer_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_rd    (push_rd),
        .push_data  (push_data),
        .pop        (pop),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .head_ptr   (head_ptr),
        .entry_vld  (entry_vld),
        .entry_rd   (entry_rd),
        .entry_data (entry_data),
        .count      (count),
        .full       (full),
        .empty      (fifo_empty)
    );

    assign empty         = fifo_empty;
    assign RegWrite      = !fifo_empty;
    assign rd            = fifo_empty ? '0 : head_rd;
    assign rd_write_data = fifo_empty ? '0 : head_data;

    // Walk slots oldest-to-youngest from the head; a later match overwrites an
    // earlier one, so the youngest pending value wins.
    always_comb begin
        rs1_fwd_hit  = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_hit  = 1'b0;
        rs2_fwd_data = '0;
        idx          = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PTR_W'(k);
            if (entry_vld[idx] && (rs1 != REG_ZERO) &&
                (entry_rd[idx*ADDR_W +: ADDR_W] == rs1)) begin
                rs1_fwd_hit  = 1'b1;
                rs1_fwd_data = entry_data[idx*DATA_W +: DATA_W];
            end
            if (entry_vld[idx] && (rs2 != REG_ZERO) &&
                (entry_rd[idx*ADDR_W +: ADDR_W] == rs2)) begin
                rs2_fwd_hit  = 1'b1;
                rs2_fwd_data = entry_data[idx*DATA_W +: DATA_W];
            end
        end
    end

endmodule
